// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clock period meter.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeas
    } state_e;

    localparam int unsigned AVG_DEPTH = 4;
    localparam int unsigned AVG_SHIFT = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous input with registered rise/fall strobes.
// level is the synchronised value aligned with the strobes.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        dly_d  = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~dly_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & dly_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    always_comb begin
        level = dly_q;
        rise  = rise_q;
        fall  = fall_q;
    end

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous clock in system-clock cycles, with timeout.
// Define CLK_PERIOD_METER_AVG_EN to publish the truncated mean of every 4 measurements.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned      CNT_W       = 28,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(1000000),
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] ht_q, ht_d;
    logic             frz_q, frz_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             level, rise, fall;
    logic             active, cnt_sat, tmo_hit, publish;
`ifdef CLK_PERIOD_METER_AVG_EN
    logic [CNT_W+1:0] acc_p_q, acc_p_d, acc_h_q, acc_h_d, sum_p, sum_h;
    logic [1:0]       idx_q, idx_d;
`endif

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_in(sig_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        active  = meas_en && (state_q == StArm || state_q == StMeas);
        cnt_sat = (cnt_q == TIMEOUT);
        // A rise on the saturating cycle still counts as a valid measurement.
        tmo_hit = active && !rise && cnt_sat;
        publish = meas_en && (state_q == StMeas) && rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!meas_en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  state_d = StArm;
                StArm:   if (rise) state_d = StMeas;
                StMeas:  if (tmo_hit) state_d = StArm;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        high_d    = high_q;
        frz_d     = frz_q;
        period_d  = period_q;
        ht_d      = ht_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!meas_en) begin
            cnt_d  = '0;
            high_d = '0;
            frz_d  = 1'b0;
        end else if (active && rise) begin
            cnt_d  = CNT_W'(1);
            high_d = CNT_W'(1);
            frz_d  = 1'b0;
        end else if (active) begin
            if (cnt_sat) begin
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (level && !frz_q && high_q != TIMEOUT) begin
                high_d = high_q + 1'b1;
            end
            if (fall) begin
                frz_d = 1'b1;
            end
        end
`ifdef CLK_PERIOD_METER_AVG_EN
        acc_p_d = acc_p_q;
        acc_h_d = acc_h_q;
        idx_d   = idx_q;
        sum_p   = acc_p_q + (CNT_W+2)'(cnt_q);
        sum_h   = acc_h_q + (CNT_W+2)'(high_q);
        if (!meas_en || tmo_hit) begin
            acc_p_d = '0;
            acc_h_d = '0;
            idx_d   = '0;
        end else if (publish) begin
            timeout_d = 1'b0;
            if (idx_q == 2'(AVG_DEPTH - 1)) begin
                period_d = CNT_W'(sum_p >> AVG_SHIFT);
                ht_d     = CNT_W'(sum_h >> AVG_SHIFT);
                valid_d  = 1'b1;
                acc_p_d  = '0;
                acc_h_d  = '0;
                idx_d    = '0;
            end else begin
                acc_p_d = sum_p;
                acc_h_d = sum_h;
                idx_d   = idx_q + 2'd1;
            end
        end
`else
        if (publish) begin
            period_d  = cnt_q;
            ht_d      = high_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            high_q    <= '0;
            frz_q     <= 1'b0;
            period_q  <= '0;
            ht_q      <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
            acc_p_q   <= '0;
            acc_h_q   <= '0;
            idx_q     <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            high_q    <= high_d;
            frz_q     <= frz_d;
            period_q  <= period_d;
            ht_q      <= ht_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
`ifdef CLK_PERIOD_METER_AVG_EN
            acc_p_q   <= acc_p_d;
            acc_h_q   <= acc_h_d;
            idx_q     <= idx_d;
`endif
        end
    end

    always_comb begin
        period       = period_q;
        high_time    = ht_q;
        period_valid = valid_q;
        timeout      = timeout_q;
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: waveform-level reference model plus directed tables.
module tb_clk_period_meter;
    localparam int unsigned CNT_W = 28;
    localparam int unsigned TMO   = 100;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sig_in = 1'b0;
    logic             meas_en = 1'b0;
    logic [CNT_W-1:0] period, high_time;
    logic             period_valid, timeout;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (CNT_W'(TMO)),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .meas_en     (meas_en),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned div;
        int unsigned exp_period;
        int unsigned exp_high;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned valid_cnt = 0, last_valid_cyc = 0, prev_valid_cyc = 0;
    int unsigned exp_p[$], exp_h[$];
    int unsigned avg_p[$], avg_h[$];
    bit          armed = 1'b0;
    int unsigned last_rise = 0, prev_h = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && period_valid) begin
            valid_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            check("valid_was_expected", exp_p.size() > 0, 1);
            if (exp_p.size() > 0) begin
                check("period", period, exp_p.pop_front());
                check("high_time", high_time, exp_h.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_avg();
        avg_p.delete();
        avg_h.delete();
    endtask

    // One completed measurement: interval between rises and the high run inside it.
    task automatic measured(input int unsigned p, input int unsigned h);
`ifdef CLK_PERIOD_METER_AVG_EN
        int unsigned sp = 0, sh = 0;
        avg_p.push_back(p);
        avg_h.push_back(h);
        if (avg_p.size() == 4) begin
            foreach (avg_p[i]) begin
                sp += avg_p[i];
                sh += avg_h[i];
            end
            exp_p.push_back(sp / 4);
            exp_h.push_back(sh / 4);
            clear_avg();
        end
`else
        exp_p.push_back(p);
        exp_h.push_back(h);
`endif
    endtask

    task automatic note_rise(input int unsigned h);
        int unsigned gap;
        gap = cyc - last_rise;
        if (armed && gap <= TMO) measured(gap, prev_h);
        else if (armed) clear_avg();
        armed     = 1'b1;
        last_rise = cyc;
        prev_h    = h;
    endtask

    task automatic drive_period(input int unsigned p, input int unsigned h);
        note_rise(h);
        sig_in = 1'b1;
        repeat (h) tick();
        sig_in = 1'b0;
        repeat (p - h) tick();
    endtask

    task automatic idle(input int unsigned n);
        sig_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic enable();
        meas_en = 1'b0;
        repeat (2) tick();
        meas_en = 1'b1;
        armed   = 1'b0;
        clear_avg();
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[4];
        int unsigned v0, r;

        vecs[0] = '{div: 2,  exp_period: 3,  exp_high: 1};
        vecs[1] = '{div: 8,  exp_period: 9,  exp_high: 4};
        vecs[2] = '{div: 5,  exp_period: 6,  exp_high: 2};
        vecs[3] = '{div: 15, exp_period: 16, exp_high: 7};

        repeat (3) tick();
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", period_valid, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        tick();

`ifdef CLK_PERIOD_METER_AVG_EN
        enable();
        v0 = valid_cnt;
        drive_period(8, 3);
        drive_period(9, 3);
        drive_period(10, 4);
        drive_period(11, 5);
        check("avg_no_early_valid", valid_cnt, v0);
        drive_period(12, 5);
        idle(8);
        check("avg_one_valid", valid_cnt, v0 + 1);
        check("avg_period", period, 9);
        check("avg_high", high_time, 3);
        check("avg_drain", exp_p.size(), 0);
`else
        // Divider-model table: period = div + 1, high = div / 2.
        foreach (vecs[i]) begin
            enable();
            v0 = valid_cnt;
            for (int k = 0; k < 6; k++) drive_period(vecs[i].div + 1, vecs[i].div / 2);
            idle(8);
            check("tbl_period", period, vecs[i].exp_period);
            check("tbl_high", high_time, vecs[i].exp_high);
            check("tbl_spacing", last_valid_cyc - prev_valid_cyc, vecs[i].exp_period);
            check("tbl_count", valid_cnt - v0, 5);
            check("tbl_drain", exp_p.size(), 0);
        end

        // Timeout after sig_in stops, then recovery on the next valid.
        enable();
        for (int k = 0; k < 4; k++) drive_period(9, 4);
        r  = last_rise;
        v0 = valid_cnt;
        while (cyc < r + 103) tick();
        check("tmo_not_early", timeout, 0);
        tick();
        check("tmo_set", timeout, 1);
        repeat (20) tick();
        check("tmo_no_valid", valid_cnt, v0);
        drive_period(9, 4);
        check("tmo_held_after_arm", timeout, 1);
        drive_period(9, 4);
        idle(6);
        check("tmo_cleared", timeout, 0);
        check("tmo_drain", exp_p.size(), 0);

        // Gap of exactly TIMEOUT is a valid period; one more cycle is a timeout.
        enable();
        v0 = valid_cnt;
        drive_period(10, 3);
        drive_period(100, 3);
        note_rise(3);
        sig_in = 1'b1;
        repeat (3) tick();
        sig_in = 1'b0;
        repeat (7) tick();
        check("bnd_no_tmo_at_limit", timeout, 0);
        repeat (91) tick();
        drive_period(10, 3);
        check("bnd_tmo_past_limit", timeout, 1);
        idle(8);
        check("bnd_count", valid_cnt - v0, 2);
        check("bnd_drain", exp_p.size(), 0);

        // Drop meas_en mid-period: outputs hold, two rises needed after re-enable.
        enable();
        for (int k = 0; k < 3; k++) drive_period(9, 4);
        note_rise(4);
        sig_in = 1'b1;
        repeat (4) tick();
        sig_in = 1'b0;
        repeat (2) tick();
        meas_en = 1'b0;
        v0 = valid_cnt;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("dis_period_hold", period, 9);
            check("dis_high_hold", high_time, 4);
        end
        check("dis_no_valid", valid_cnt, v0);
        meas_en = 1'b1;
        armed   = 1'b0;
        repeat (3) tick();
        drive_period(9, 4);
        check("reen_first_rise_no_valid", valid_cnt, v0);
        for (int k = 0; k < 3; k++) drive_period(9, 4);
        idle(8);
        check("reen_count", valid_cnt - v0, 3);
        check("reen_drain", exp_p.size(), 0);

        // One-cycle reset during MEAS.
        enable();
        for (int k = 0; k < 3; k++) drive_period(9, 4);
        rst_n = 1'b0;
        tick();
        check("mrst_period", period, 0);
        check("mrst_high", high_time, 0);
        check("mrst_valid", period_valid, 0);
        check("mrst_timeout", timeout, 0);
        rst_n = 1'b1;
        armed = 1'b0;
        v0    = valid_cnt;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) drive_period(7, 2);
        idle(8);
        check("mrst_count", valid_cnt - v0, 2);
        check("mrst_new_period", period, 7);
        check("mrst_drain", exp_p.size(), 0);

        // Randomised waveforms, including gaps around the timeout limit.
        enable();
        for (int k = 0; k < 40; k++) begin
            int unsigned p, h;
            if ($urandom_range(7, 0) == 0) p = $urandom_range(102, 98);
            else p = $urandom_range(40, 2);
            h = $urandom_range(p - 1, 1);
            drive_period(p, h);
        end
        idle(10);
        check("rnd_drain", exp_p.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
